// File: rtl/fxp_divider_param.sv
// Unsigned fixed-point divider: restoring division of {a, FRAC zeros} by b,
// one quotient bit per clock, with divide-by-zero and quotient-overflow flags.
module fxp_divider_param #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dvz,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepting edge
  // INIT  | divide-by-zero check, load dividend and counter
  // ITER  | one restoring-division step per cycle, MSB first
  // DONE  | results settled; valid follows one cycle later
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_cap, b_cap;
  logic [N-1:0]     d_sr;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   p_shift, p_sub;
  logic [WIDTH-1:0] q_acc;
  logic [CW-1:0]    cnt;
  logic             q_bit, ovf_hit, last;

  always_comb begin
    p_shift = {p[WIDTH-1:0], d_sr[N-1]};
    q_bit   = (p_shift >= {1'b0, b_cap});
    p_sub   = q_bit ? (p_shift - {1'b0, b_cap}) : p_shift;
    // cnt equals the bit position of the quotient bit being produced
    ovf_hit = q_bit && (cnt >= CW'(WIDTH));
    last    = (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = INIT;
      INIT: begin
        busy      = 1'b1;
        state_nxt = (b_cap == '0) ? DONE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (ovf_hit || last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cap <= '0;
      b_cap <= '0;
      d_sr  <= '0;
      p     <= '0;
      q_acc <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dvz   <= 1'b0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_cap <= a;
            b_cap <= b;
            dvz   <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        INIT: begin
          if (b_cap == '0) begin
            dvz <= 1'b1;
            q   <= '1;
            r   <= '0;
          end else begin
            p     <= '0;
            d_sr  <= N'(a_cap) << FRAC;
            q_acc <= '0;
            cnt   <= CW'(N - 1);
          end
        end
        ITER: begin
          p     <= p_sub;
          d_sr  <= d_sr << 1;
          cnt   <= cnt - 1'b1;
          q_acc <= {q_acc[WIDTH-2:0], q_bit};
          if (ovf_hit) begin
            ovf <= 1'b1;
            q   <= '1;
            r   <= '0;
          end else if (last) begin
            q <= {q_acc[WIDTH-2:0], q_bit};
            // p_sub < b, so the top bit is always zero here
            r <= p_sub[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_divider_param.sv
// Scoreboard bench for fxp_divider_param at WIDTH=16, FRAC=8: expected results
// and valid timing come from an arithmetic reference model.
module tb_fxp_divider_param;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int N     = WIDTH + FRAC;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, valid, dvz, ovf;
  logic [WIDTH-1:0] q, r;

  fxp_divider_param #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .valid(valid), .q(q), .r(r), .dvz(dvz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dvz;
    logic             ovf;
    int               vcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) chk("spurious_valid", 32'(valid), 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("q",   32'(q),   32'(mon_e.q));
        chk("r",   32'(r),   32'(mon_e.r));
        chk("dvz", 32'(dvz), 32'(mon_e.dvz));
        chk("ovf", 32'(ovf), 32'(mon_e.ovf));
        chk("valid_cycle", 32'(cyc), 32'(mon_e.vcyc));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_q"},     32'(q),     32'd0);
    chk({tag, "_r"},     32'(r),     32'd0);
    chk({tag, "_dvz"},   32'(dvz),   32'd0);
    chk({tag, "_ovf"},   32'(ovf),   32'd0);
  endtask

  // rst_at >= 0: assert reset when that many busy cycles have been seen
  task automatic do_div(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input bit disturb, input int rst_at);
    exp_t   e;
    longint dd, qf;
    int     msb, k, exp_busy, bcnt;
    bit     seen;
    dd = longint'(ta) << FRAC;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    k = cyc + 1;
    if (tb_v == 0) begin
      e.q = '1; e.r = '0; e.dvz = 1'b1; e.ovf = 1'b0;
      e.vcyc = k + 2; exp_busy = 1;
    end else begin
      qf = dd / longint'(tb_v);
      if (qf >= (64'd1 << WIDTH)) begin
        msb = 0;
        for (int i = 0; i < 64; i++) if (qf[i]) msb = i;
        e.q = '1; e.r = '0; e.dvz = 1'b0; e.ovf = 1'b1;
        e.vcyc = k + N - msb + 2; exp_busy = N - msb + 1;
      end else begin
        e.q = qf[WIDTH-1:0];
        e.r = WIDTH'(dd % longint'(tb_v));
        e.dvz = 1'b0; e.ovf = 1'b0;
        e.vcyc = k + N + 2; exp_busy = N + 1;
      end
    end
    if (rst_at < 0) sb.push_back(e);
    @(negedge clk);
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
    chk("dvz_clear_on_start", 32'(dvz), 32'd0);
    chk("ovf_clear_on_start", 32'(ovf), 32'd0);
    bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (valid) seen = 1'b1;
      else begin
        if (busy) bcnt++;
        if (rst_at >= 0 && bcnt == rst_at) begin
          rst = 1'b1;
          #1 check_all_zero("rst_mid");
          repeat (3) begin
            @(negedge clk);
            chk("rst_hold_valid", 32'(valid), 32'd0);
          end
          rst = 1'b0;
          repeat (30) @(negedge clk);
          return;
        end
        if (disturb && i == 5) begin
          start = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
        end
        if (disturb && i == 6) start = 1'b0;
        @(negedge clk);
      end
    end
    chk("valid_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("busy_len", 32'(bcnt), 32'(exp_busy));
      @(negedge clk);
      chk("valid_one_cycle", 32'(valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    do_div(16'h0300, 16'h0200, 1'b0, -1);
    do_div(16'h0100, 16'h0300, 1'b0, -1);
    do_div(16'hFFFF, 16'h0100, 1'b0, -1);
    do_div(16'hFF00, 16'h0001, 1'b0, -1);
    do_div(16'h1234, 16'h0000, 1'b0, -1);
    do_div(16'h0040, 16'h0020, 1'b0, -1);
    do_div(16'h5A5A, 16'h0123, 1'b1, -1);
    do_div(16'h4000, 16'h0300, 1'b0, 11);
    do_div(16'h0700, 16'h0380, 1'b0, -1);
    for (int i = 0; i < 6; i++)
      do_div(WIDTH'($urandom), WIDTH'($urandom_range(1, 16'hFFFF)), 1'b0, -1);
    for (int i = 0; i < 3; i++)
      do_div(WIDTH'($urandom), WIDTH'($urandom_range(1, 16'h00FF)), 1'b0, -1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
